rob_commit: RTL and testbench
=============================

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameter DATA_W, default 32, data width of result bus and commit data.
REQ-002 Parameter REG_W, default 5, architectural register name width.
REQ-003 Parameter ENTRY_W, default 3, entry index width; depth = 2^ENTRY_W (8).
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 alloc_valid  in  1  decoder requests one entry this cycle.
REQ-007 alloc_reg  in  REG_W  destination register of the allocating instruction.
REQ-008 alloc_ready  out  1  buffer not full; allocation accepted iff alloc_valid && alloc_ready.
REQ-009 alloc_entry  out  ENTRY_W  index granted to the allocating instruction (current tail).
REQ-010 cdb_valid  in  1  result broadcast present.
REQ-011 cdb_entry  in  ENTRY_W  entry the result belongs to.
REQ-012 cdb_data  in  DATA_W  result value.
REQ-013 q_entry  in  ENTRY_W  operand query index from decoder.
REQ-014 q_ready / q_data  out  1 / DATA_W  queried entry is done / its value (0 if not done).
REQ-015 ROB_we  out  1  commit strobe toward register file.
REQ-016 namew / dataw / entryw  out  REG_W / DATA_W / ENTRY_W  committed register, value, entry.
REQ-017 flush  in  1  pipeline flush (present only with ROB_FLUSH_EN).

Function
REQ-018 Circular buffer; head, tail pointers ENTRY_W bits, wrap modulo depth; count ENTRY_W+1 bits, 0..depth.
REQ-019 Per entry: busy, done, reg, data.
REQ-020 alloc_ready = (count != depth), combinational; no credit for a same-cycle commit.
REQ-021 Accepted allocation: entry[tail] busy=1, done=0, reg=alloc_reg; tail+1; alloc_entry = tail before the edge.
REQ-022 cdb_valid with busy entry: done=1, data=cdb_data; cdb to non-busy entry ignored.
REQ-023 Commit: when entry[head] busy && done (registered state), at the edge: busy=0, head+1, and ROB_we=1, namew/dataw/entryw = that entry's reg/data/index registered for the next cycle.
REQ-024 ROB_we is 0 in every cycle following an edge with no commit; namew/dataw/entryw hold last values.
REQ-025 At most one commit and one allocation per cycle; count += alloc - commit; simultaneous alloc and commit leave count unchanged.
REQ-026 cdb to head entry in cycle N: commit occurs at edge N+1 (no same-cycle bypass into commit).
REQ-027 q_ready/q_data combinational from stored state, plus bypass: cdb_valid && cdb_entry==q_entry && busy gives q_ready=1, q_data=cdb_data.
REQ-028 Register 0 destinations are committed normally; suppression is the register file's duty.

Reset
REQ-029 rst asserted: head=tail=count=0, all busy/done=0, ROB_we=0, namew=0, dataw=0, entryw=0, immediately and independent of clk.
REQ-030 Reset mid-operation discards all in-flight entries; no commit strobe issued during or on the first edge after release.

Configuration
REQ-031 Macro ROB_FLUSH_EN: defined -> flush port exists; flush=1 at an edge clears head, tail, count, all busy/done, ROB_we=0, overriding same-cycle alloc, cdb and commit.
REQ-032 ROB_FLUSH_EN undefined -> no flush port, no flush logic; emptying only via rst.

Verification
REQ-033 Reset, 8 allocations reg 1..8 -> alloc_entry 0..7, alloc_ready=0 after 8th; 9th request not accepted.
REQ-034 cdb entry 1 data 0x11 then entry 0 data 0x10 -> commits in order: ROB_we with namew=1 dataw=0x10 entryw=0, next cycle namew=2 dataw=0x11 entryw=1.
REQ-035 Full buffer, head done, alloc_valid=1 same cycle -> commit occurs, allocation refused, alloc_ready=1 next cycle.
REQ-036 Wrap: 12 alloc/commit pairs -> tail and head wrap 7->0, entryw sequence 0..7,0..3, count never exceeds 8.
REQ-037 q_entry=3 while cdb_entry=3 data 0xAB -> q_ready=1, q_data=0xAB same cycle.
REQ-038 ROB_FLUSH_EN: 5 busy entries, flush=1 -> count=0, alloc_entry=0, no ROB_we afterward; rst asserted mid-commit -> ROB_we=0 immediately.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: in-order reorder buffer with a single commit port.
// Entries are allocated at the tail and filled by result broadcasts.
// Completed entries retire from the head one per cycle, through a registered
// commit bus (ROB_we / namew / dataw / entryw).
// Optional feature macro: ROB_FLUSH_EN adds a 'flush' input. A flush empties
// the buffer at the next rising edge.
module rob_commit #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int ENTRY_W = 3
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ROB_FLUSH_EN
    input  logic               flush,
`endif
    input  logic               alloc_valid,
    input  logic [REG_W-1:0]   alloc_reg,
    output logic               alloc_ready,
    output logic [ENTRY_W-1:0] alloc_entry,
    input  logic               cdb_valid,
    input  logic [ENTRY_W-1:0] cdb_entry,
    input  logic [DATA_W-1:0]  cdb_data,
    input  logic [ENTRY_W-1:0] q_entry,
    output logic               q_ready,
    output logic [DATA_W-1:0]  q_data,
    output logic               ROB_we,
    output logic [REG_W-1:0]   namew,
    output logic [DATA_W-1:0]  dataw,
    output logic [ENTRY_W-1:0] entryw
);
    localparam int DEPTH = 1 << ENTRY_W;
    localparam logic [ENTRY_W:0] FULL = DEPTH[ENTRY_W:0];

    logic [DEPTH-1:0]   busy_q, done_q;
    logic [REG_W-1:0]   reg_q  [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [ENTRY_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [ENTRY_W:0]   count_q, count_d;
    logic               we_q;
    logic [REG_W-1:0]   namew_q;
    logic [DATA_W-1:0]  dataw_q;
    logic [ENTRY_W-1:0] entryw_q;
    logic               alloc_fire, commit_fire, cdb_hit;

    // A retiring slot never frees space for a same-cycle allocation.
    assign alloc_ready = (count_q != FULL);
    assign alloc_entry = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    // Commit looks only at registered state, so a broadcast retires one cycle later.
    assign commit_fire = busy_q[head_q] && done_q[head_q];
    // Results aimed at idle slots are stale and dropped.
    assign cdb_hit     = cdb_valid && busy_q[cdb_entry];

    assign ROB_we = we_q;
    assign namew  = namew_q;
    assign dataw  = dataw_q;
    assign entryw = entryw_q;

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (alloc_fire)  tail_d = tail_q + 1'b1;
        if (commit_fire) head_d = head_q + 1'b1;
        case ({alloc_fire, commit_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
`ifdef ROB_FLUSH_EN
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
`endif
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Per-entry status: allocate sets busy, broadcast sets done, commit clears both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            done_q <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            busy_q <= '0;
            done_q <= '0;
        end
`endif
        else begin
            if (cdb_hit) done_q[cdb_entry] <= 1'b1;
            if (commit_fire) begin
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
            end
            if (alloc_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
            end
        end
    end

    // Payload storage; validity is tracked by busy/done, so no reset is needed.
    always_ff @(posedge clk) begin
        if (alloc_fire) reg_q[tail_q]     <= alloc_reg;
        if (cdb_hit)    data_q[cdb_entry] <= cdb_data;
    end

    // Registered commit bus; name/data/entry hold between commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            namew_q  <= '0;
            dataw_q  <= '0;
            entryw_q <= '0;
        end
`ifdef ROB_FLUSH_EN
        else if (flush) begin
            we_q <= 1'b0;
        end
`endif
        else begin
            we_q <= commit_fire;
            if (commit_fire) begin
                namew_q  <= reg_q[head_q];
                dataw_q  <= data_q[head_q];
                entryw_q <= head_q;
            end
        end
    end

    // Operand query: a live broadcast to a busy slot overrides stored state.
    always_comb begin
        q_ready = done_q[q_entry];
        q_data  = done_q[q_entry] ? data_q[q_entry] : '0;
        if (cdb_valid && (cdb_entry == q_entry) && busy_q[q_entry]) begin
            q_ready = 1'b1;
            q_data  = cdb_data;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed table of vectors plus hand sequences for wrap,
// reset-mid-commit and (when ROB_FLUSH_EN is defined) flush.
module tb_rob_commit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_reg = '0;
    logic        alloc_ready;
    logic [2:0]  alloc_entry;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_entry = '0;
    logic [31:0] cdb_data = '0;
    logic [2:0]  q_entry = '0;
    logic        q_ready;
    logic [31:0] q_data;
    logic        ROB_we;
    logic [4:0]  namew;
    logic [31:0] dataw;
    logic [2:0]  entryw;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rob_commit dut (
        .clk(clk), .rst(rst),
`ifdef ROB_FLUSH_EN
        .flush(flush),
`endif
        .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
        .alloc_ready(alloc_ready), .alloc_entry(alloc_entry),
        .cdb_valid(cdb_valid), .cdb_entry(cdb_entry), .cdb_data(cdb_data),
        .q_entry(q_entry), .q_ready(q_ready), .q_data(q_data),
        .ROB_we(ROB_we), .namew(namew), .dataw(dataw), .entryw(entryw)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic        cv;
        logic [2:0]  ce;
        logic [31:0] cd;
        logic [2:0]  qe;
        logic        e_rdy;
        logic [2:0]  e_ent;
        logic        e_qr;
        logic [31:0] e_qd;
        logic        e_we;
        logic [4:0]  e_nm;
        logic [31:0] e_dw;
        logic [2:0]  e_ew;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input int av, input int ar, input int cv, input int ce,
                                input int cd, input int qe, input int rdy, input int ent,
                                input int qr, input int qd, input int we, input int nm,
                                input int dw, input int ew);
        vec_t v;
        v.av = av[0]; v.ar = ar[4:0]; v.cv = cv[0]; v.ce = ce[2:0];
        v.cd = cd; v.qe = qe[2:0]; v.e_rdy = rdy[0]; v.e_ent = ent[2:0];
        v.e_qr = qr[0]; v.e_qd = qd; v.e_we = we[0]; v.e_nm = nm[4:0];
        v.e_dw = dw; v.e_ew = ew[2:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int av, input int ar, input int cv, input int ce,
                         input int cd, input int qe);
        alloc_valid = av[0];
        alloc_reg   = ar[4:0];
        cdb_valid   = cv[0];
        cdb_entry   = ce[2:0];
        cdb_data    = cd;
        q_entry     = qe[2:0];
    endtask

    // One cycle: wait for the falling edge, drive, settle.
    task automatic step(input int av, input int ar, input int cv, input int ce,
                        input int cd, input int qe);
        @(negedge clk);
        drive(av, ar, cv, ce, cd, qe);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Fill table: fill to full, reject 9th, out-of-order completion, in-order commit,
        // full+commit+alloc, operand bypass, stale broadcast ignored.
        tbl[0] = mk(0,0,0,0,0,0,       1,0,0,0,         0,0,0,0);
        for (int i = 1; i <= 8; i++)
            tbl[i] = mk(1,i,0,0,0,0,   1,i-1,0,0,       0,0,0,0);
        tbl[9]  = mk(1,9,0,0,0,0,      0,0,0,0,         0,0,0,0);
        tbl[10] = mk(0,0,1,1,'h11,1,   0,0,1,'h11,      0,0,0,0);
        tbl[11] = mk(0,0,1,0,'h10,1,   0,0,1,'h11,      0,0,0,0);
        tbl[12] = mk(1,9,0,0,0,0,      0,0,1,'h10,      0,0,0,0);
        tbl[13] = mk(0,0,0,0,0,0,      1,0,0,0,         1,1,'h10,0);
        tbl[14] = mk(0,0,0,0,0,1,      1,0,0,0,         1,2,'h11,1);
        tbl[15] = mk(0,0,0,0,0,3,      1,0,0,0,         0,2,'h11,1);
        tbl[16] = mk(0,0,1,3,'hAB,3,   1,0,1,'hAB,      0,2,'h11,1);
        tbl[17] = mk(0,0,1,0,'h55,0,   1,0,0,0,         0,2,'h11,1);
        tbl[18] = mk(0,0,0,0,0,3,      1,0,1,'hAB,      0,2,'h11,1);
        tbl[19] = mk(0,0,0,0,0,0,      1,0,0,0,         0,2,'h11,1);

        // Reset state while rst is held.
        #2;
        chk("rst ROB_we", 32'(ROB_we), 0);
        chk("rst namew", 32'(namew), 0);
        chk("rst dataw", dataw, 0);
        chk("rst entryw", 32'(entryw), 0);
        chk("rst alloc_ready", 32'(alloc_ready), 1);
        chk("rst alloc_entry", 32'(alloc_entry), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 20; k++) begin
            step(tbl[k].av, tbl[k].ar, tbl[k].cv, tbl[k].ce, tbl[k].cd, tbl[k].qe);
            chk($sformatf("v%0d alloc_ready", k), 32'(alloc_ready), 32'(tbl[k].e_rdy));
            chk($sformatf("v%0d alloc_entry", k), 32'(alloc_entry), 32'(tbl[k].e_ent));
            chk($sformatf("v%0d q_ready", k),     32'(q_ready),     32'(tbl[k].e_qr));
            chk($sformatf("v%0d q_data", k),      q_data,           tbl[k].e_qd);
            chk($sformatf("v%0d ROB_we", k),      32'(ROB_we),      32'(tbl[k].e_we));
            chk($sformatf("v%0d namew", k),       32'(namew),       32'(tbl[k].e_nm));
            chk($sformatf("v%0d dataw", k),       dataw,            tbl[k].e_dw);
            chk($sformatf("v%0d entryw", k),      32'(entryw),      32'(tbl[k].e_ew));
        end

        // Wrap: 12 allocate/complete/commit rounds; pointers wrap 7->0.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, i + 1, 0, 0, 0, 0);
            chk($sformatf("wrap%0d alloc_ready", i), 32'(alloc_ready), 1);
            chk($sformatf("wrap%0d alloc_entry", i), 32'(alloc_entry), 32'(i % 8));
            step(0, 0, 1, i % 8, 'h100 + i, 0);
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("wrap%0d idle ROB_we", i), 32'(ROB_we), 0);
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("wrap%0d ROB_we", i), 32'(ROB_we), 1);
            chk($sformatf("wrap%0d namew", i),  32'(namew), 32'(i + 1));
            chk($sformatf("wrap%0d dataw", i),  dataw, 32'('h100 + i));
            chk($sformatf("wrap%0d entryw", i), 32'(entryw), 32'(i % 8));
        end

        // Reset while the commit strobe is high: outputs clear without a clock edge.
        rst = 1'b1;
        #1;
        chk("midrst ROB_we", 32'(ROB_we), 0);
        chk("midrst namew", 32'(namew), 0);
        chk("midrst dataw", dataw, 0);
        chk("midrst entryw", 32'(entryw), 0);
        chk("midrst alloc_entry", 32'(alloc_entry), 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 0);
        chk("post-rst ROB_we", 32'(ROB_we), 0);
        chk("post-rst alloc_ready", 32'(alloc_ready), 1);

`ifdef ROB_FLUSH_EN
        // Five busy entries with the head done; flush beats alloc, cdb and commit.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, i + 3, 0, 0, 0, 0);
        step(0, 0, 1, 0, 'h77, 0);
        @(negedge clk);
        drive(1, 20, 1, 1, 'h88, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("flush ROB_we", 32'(ROB_we), 0);
        chk("flush alloc_entry", 32'(alloc_entry), 0);
        chk("flush alloc_ready", 32'(alloc_ready), 1);
        chk("flush q_ready", 32'(q_ready), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("flush+1 ROB_we", 32'(ROB_we), 0);
        // Count restarted at zero: exactly eight more allocations fit.
        for (int i = 0; i < 8; i++) begin
            step(1, i + 1, 0, 0, 0, 0);
            chk($sformatf("refill%0d alloc_entry", i), 32'(alloc_entry), 32'(i));
        end
        step(0, 0, 0, 0, 0, 0);
        chk("refill full alloc_ready", 32'(alloc_ready), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
